midi_voice_allocator: RTL

Takes the byte stream from the MIDI UART receiver, parses channel-voice messages with running status, and schedules note-on/off events onto a fixed pool of synth voices. When all voices are busy, it steals the oldest one. It sits between the MIDI input module and the oscillator/envelope voices, and it is the only block that drives voice gate, pitch and velocity.

---
 rtl/midi_pkg.sv | 21 ++
 rtl/midi_msg_parser.sv | 91 +++++++++
 rtl/midi_voice_allocator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI voice allocator.
//   - Status-byte high nibbles for the channel-voice messages we decode.
//   - Controller number for "All Notes Off".
//   - Parser state encoding used by midi_msg_parser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;

    typedef enum logic [1:0] {
        WAIT_STATUS,
        DATA1,
        DATA2
    } parse_state_e;

endpackage

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: turns the raw MIDI byte stream into complete channel
// messages, honouring running status.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_in         received byte, stable while byte_valid is high
//   byte_valid      receiver level; each rising edge is one new byte
//   msg_valid       one-cycle pulse, cycle after the final data byte
//   status, d1, d2  status byte and data bytes of the completed message
module midi_msg_parser
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       msg_valid,
    output logic [7:0] status,
    output logic [6:0] d1,
    output logic [6:0] d2
);

    logic         vld_dly_q, vld_dly_d;
    parse_state_e state_q, state_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   d1_q, d1_d;
    logic [6:0]   d2_q, d2_d;
    logic         msg_valid_q, msg_valid_d;

    logic accept;
    assign accept = byte_valid & ~vld_dly_q;

    always_comb begin
        vld_dly_d   = byte_valid;
        state_d     = state_q;
        status_d    = status_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        msg_valid_d = 1'b0;
        if (accept) begin
            if (byte_in >= 8'hF8) begin
                // real-time: transparent to the parser
            end else if (byte_in >= 8'hF0) begin
                status_d = 8'h00;
                state_d  = WAIT_STATUS;
            end else if (byte_in[7]) begin
                status_d = byte_in;
                state_d  = DATA1;
            end else begin
                case (state_q)
                    DATA1: begin
                        d1_d = byte_in[6:0];
                        if (status_q[7:4] == PROG || status_q[7:4] == CHAN_PRESS)
                            msg_valid_d = 1'b1;
                        else
                            state_d = DATA2;
                    end
                    DATA2: begin
                        d2_d        = byte_in[6:0];
                        msg_valid_d = 1'b1;
                        state_d     = DATA1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_dly_q   <= 1'b0;
            state_q     <= WAIT_STATUS;
            status_q    <= 8'h00;
            d1_q        <= 7'h00;
            d2_q        <= 7'h00;
            msg_valid_q <= 1'b0;
        end else begin
            vld_dly_q   <= vld_dly_d;
            state_q     <= state_d;
            status_q    <= status_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            msg_valid_q <= msg_valid_d;
        end
    end

    assign msg_valid = msg_valid_q;
    assign status    = status_q;
    assign d1        = d1_q;
    assign d2        = d2_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: schedules note-on/off events from the MIDI stream
// onto a pool of VOICES synth voices, stealing the oldest when all are busy.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   byte_in      received MIDI byte
//   byte_valid   receiver level; rising edge = new byte
//   voice_gate   per-voice gate
//   voice_note   7 bits per voice, voice i at [7i+6:7i]
//   voice_vel    7 bits per voice
//   voice_trig   one-cycle envelope restart pulse per voice
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [VOICES-1:0]     voice_gate,
    output logic [7*VOICES-1:0]   voice_note,
    output logic [7*VOICES-1:0]   voice_vel,
    output logic [VOICES-1:0]     voice_trig
);

    localparam int AW = $clog2(VOICES);

    logic       msg_valid;
    logic [7:0] status;
    logic [6:0] d1, d2;

    midi_msg_parser u_parser (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .msg_valid  (msg_valid),
        .status     (status),
        .d1         (d1),
        .d2         (d2)
    );

    logic [VOICES-1:0]         gate_q, gate_d;
    logic [VOICES-1:0][6:0]    note_q, note_d;
    logic [VOICES-1:0][6:0]    vel_q, vel_d;
    logic [VOICES-1:0][AW-1:0] age_q, age_d;
    logic [VOICES-1:0]         trig_q, trig_d;

    logic do_on, do_off, do_all_off, on_chan;
    assign on_chan    = msg_valid && (status[3:0] == 4'(CHANNEL));
    assign do_on      = on_chan && status[7:4] == NOTE_ON && d2 != 7'd0;
    assign do_off     = on_chan && (status[7:4] == NOTE_OFF ||
                                    (status[7:4] == NOTE_ON && d2 == 7'd0));
    assign do_all_off = on_chan && status[7:4] == CC && d1 == CC_ALL_NOTES_OFF;

    // Priority encoders: scan high-to-low so the lowest index wins.
    logic          match_any, free_any;
    logic [AW-1:0] sel_match, sel_free, sel_old, sel, old_age;

    always_comb begin
        match_any = 1'b0;
        free_any  = 1'b0;
        sel_match = '0;
        sel_free  = '0;
        sel_old   = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && note_q[i] == d1) begin
                match_any = 1'b1;
                sel_match = AW'(i);
            end
            if (!gate_q[i]) begin
                free_any = 1'b1;
                sel_free = AW'(i);
            end
            if (age_q[i] == AW'(VOICES - 1))
                sel_old = AW'(i);
        end
        sel     = match_any ? sel_match : (free_any ? sel_free : sel_old);
        old_age = age_q[sel];
    end

    always_comb begin
        gate_d = gate_q;
        note_d = note_q;
        vel_d  = vel_q;
        age_d  = age_q;
        trig_d = '0;
        if (do_on) begin
            // Chosen voice becomes newest; everything newer than it ages by
            // one, keeping the ages a permutation of 0..VOICES-1.
            for (int i = 0; i < VOICES; i++) begin
                if (AW'(i) == sel) begin
                    gate_d[i] = 1'b1;
                    note_d[i] = d1;
                    vel_d[i]  = d2;
                    trig_d[i] = 1'b1;
                    age_d[i]  = '0;
                end else if (age_q[i] < old_age) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
        end
        if (do_off) begin
            for (int i = 0; i < VOICES; i++)
                if (gate_q[i] && note_q[i] == d1)
                    gate_d[i] = 1'b0;
        end
        if (do_all_off)
            gate_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q <= '0;
            note_q <= '0;
            vel_q  <= '0;
            trig_q <= '0;
            for (int i = 0; i < VOICES; i++)
                age_q[i] <= AW'(i);
        end else begin
            gate_q <= gate_d;
            note_q <= note_d;
            vel_q  <= vel_d;
            age_q  <= age_d;
            trig_q <= trig_d;
        end
    end

    assign voice_gate = gate_q;
    assign voice_note = note_q;
    assign voice_vel  = vel_q;
    assign voice_trig = trig_q;

endmodule
